alu_frame_sequencer: RTL
========================

// Module: alu_frame_sequencer
// PURPOSE
//  UART-side front end of the ALU. Collects three received bytes (operand A, operand B, opcode),
//  drives the combinational ALU, captures its result and hands one result byte to the UART
//  transmitter. Sits between uart_rx/uart_tx and the ALU; the ALU is instantiated by the parent.
// PARAMETERS
//  BUS      8   ALU operand/result width; 1..8; taken from rx_data[BUS-1:0]
//  OP_W     6   ALU opcode width; taken from rx_data[OP_W-1:0]
// PORTS
//  clk         in   1     system clock, rising edge
//  rst_n       in   1     asynchronous reset, active low
//  rx_data     in   8     byte from UART receiver, valid when rx_done=1
//  rx_done     in   1     one-cycle pulse: new byte on rx_data
//  tx_done     in   1     one-cycle pulse: transmitter finished current byte
//  alu_result  in   BUS   combinational ALU output
//  alu_a       out  BUS   registered operand A to ALU
//  alu_b       out  BUS   registered operand B to ALU
//  alu_op      out  OP_W  registered opcode to ALU
//  tx_data     out  8     result byte, zero-extended from BUS; stable from tx_start until tx_done
//  tx_start    out  1     one-cycle pulse: start transmitting tx_data
//  busy        out  1     high from EXEC until tx_done returns FSM to WAIT_A
//  overrun     out  1     sticky: rx_done seen while busy; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=WAIT_A; alu_a=alu_b=0; alu_op=0; tx_data=0; tx_start=0; busy=0; overrun=0.
//  States: WAIT_A -> WAIT_B -> WAIT_OP -> EXEC -> SEND -> WAIT_TX -> WAIT_A.
//  WAIT_A/WAIT_B/WAIT_OP: on rx_done latch rx_data slice into alu_a/alu_b/alu_op, advance; else hold.
//  EXEC: one cycle; ALU inputs settled; latch tx_data <= {zeros, alu_result}; busy=1.
//  SEND: tx_start=1 for exactly this cycle; advance unconditionally.
//  WAIT_TX: hold tx_data; on tx_done -> WAIT_A, busy=0 same edge.
//  Latency: last rx_done edge -> tx_start high = 2 clk (EXEC, SEND).
//  rx_done in EXEC/SEND/WAIT_TX: byte dropped, overrun<=1; frame in flight unaffected.
//  rx_done and tx_done same cycle in WAIT_TX: go to WAIT_A, byte dropped, overrun<=1.
//  tx_done outside WAIT_TX: ignored.
//  Upper rx_data bits above BUS/OP_W ignored; arithmetic wrap/sign handled entirely by ALU.
//  rst_n low mid-frame: partial operands discarded, outputs to reset values immediately.
// CONFIGURATION
//  Macro OPCODE_CHECK_EN:
//   defined: in WAIT_OP, opcode outside {100000,100010,100100,100101,100110,100111,000011,000010}
//     skips ALU; EXEC loads tx_data=8'hFF (error byte); sequence otherwise identical.
//   undefined: any opcode passed to ALU; unsupported codes return ALU default (0).
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_ADD..OP_SRL), state enum/encoding
//   (WAIT_A..WAIT_TX, 3 bits), ERR_BYTE=8'hFF, function is_valid_op(op).
//  Single flat module; no sub-module. ALU shares alu_pkg opcode constants.
// TESTING
//  Reset then bytes 05,03,20 (ADD) -> alu_a=05, alu_b=03, tx_start 2 clk after 3rd rx_done, tx_data=08.
//  Bytes 03,05,22 (SUB) -> tx_data=FE; busy high until tx_done, then WAIT_A; overrun=0.
//  Frame 0F,F0,27 (NOR), extra rx_done=AA during WAIT_TX -> tx_data=00, overrun=1, next frame
//   0C,0A,24 (AND) -> tx_data=08.
//  Bytes 11,22 then rst_n pulse low, then 01,01,25 (OR) -> tx_data=01; no tx_start before reset release.
//  Bytes 80,01,3F: OPCODE_CHECK_EN defined -> tx_data=FF; undefined -> tx_data=00.
//  Bytes F0,02,03 (SRA, BUS=8) -> tx_data=FC; rx_done+tx_done same cycle -> WAIT_A, overrun=1.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, sequencer state encoding and opcode validation
//               shared by the ALU and its UART frame sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    localparam logic [7:0] ERR_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    // Takes the opcode zero-extended to a byte so any opcode width up to 8 fits.
    function automatic logic is_valid_op(input logic [7:0] op);
        case (op)
            {2'b00, OP_ADD}, {2'b00, OP_SUB}, {2'b00, OP_AND}, {2'b00, OP_OR},
            {2'b00, OP_XOR}, {2'b00, OP_NOR}, {2'b00, OP_SRA}, {2'b00, OP_SRL}:
                is_valid_op = 1'b1;
            default:
                is_valid_op = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_frame_sequencer.sv
// ============================================================================
// Module      : alu_frame_sequencer
// Description : Collects A, B and opcode bytes from the UART receiver, drives
//               the external ALU and returns one result byte to the transmitter.
//               Optional macro OPCODE_CHECK_EN returns ERR_BYTE for unknown opcodes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_frame_sequencer
    import alu_pkg::*;
#(
    parameter int BUS  = 8,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      rx_data,
    input  logic            rx_done,
    input  logic            tx_done,
    input  logic [BUS-1:0]  alu_result,
    output logic [BUS-1:0]  alu_a,
    output logic [BUS-1:0]  alu_b,
    output logic [OP_W-1:0] alu_op,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    output logic            busy,
    output logic            overrun
);

    state_t          state_q,   state_d;
    logic [BUS-1:0]  alu_a_q,   alu_a_d;
    logic [BUS-1:0]  alu_b_q,   alu_b_d;
    logic [OP_W-1:0] alu_op_q,  alu_op_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            overrun_q, overrun_d;
    logic            op_err_q,  op_err_d;

    logic [7:0]      result_ext;
    logic [7:0]      op_ext;
    logic            busy_w;
    logic            tx_start_w;

    always_comb begin
        result_ext = '0;
        result_ext[BUS-1:0] = alu_result;
        op_ext = '0;
        op_ext[OP_W-1:0] = rx_data[OP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
            op_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            overrun_q <= overrun_d;
            op_err_q  <= op_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        op_err_d   = op_err_q;
        busy_w     = 1'b0;
        tx_start_w = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (rx_done) begin
                    alu_a_d = rx_data[BUS-1:0];
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done) begin
                    alu_b_d = rx_data[BUS-1:0];
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (rx_done) begin
                    alu_op_d = rx_data[OP_W-1:0];
`ifdef OPCODE_CHECK_EN
                    op_err_d = !is_valid_op(op_ext);
`else
                    op_err_d = 1'b0;
`endif
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // ALU operands have been stable for a full cycle by now.
                busy_w    = 1'b1;
                tx_data_d = op_err_q ? ERR_BYTE : result_ext;
                state_d   = SEND;
            end
            SEND: begin
                busy_w     = 1'b1;
                tx_start_w = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                busy_w = 1'b1;
                if (tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase

        // Bytes arriving while a frame is in flight are dropped and flagged.
        overrun_d = overrun_q | (rx_done & busy_w);
    end

`ifndef OPCODE_CHECK_EN
    logic unused_op_ext;
    assign unused_op_ext = ^op_ext;
`endif

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_w;
    assign busy     = busy_w;
    assign overrun  = overrun_q;

endmodule

`default_nettype wire
